// File: rtl/switch_debounce.sv
// switch_debounce: per-bit two-flop synchronizer plus stable-period debouncer.
// Optional feature macro: SWITCH_DEBOUNCE_EDGE_EN adds sticky rising-edge
// capture (edge_capture), a write-1-to-clear strobe (edge_clear) and a
// registered interrupt (irq). Without the macro those ports do not exist.

// One debounced switch bit: synchronizer, stability counter, debounced level.
module switch_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CW              = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    input  logic clr_i,
    output logic cap_o,
`endif
    output logic out_o,
    output logic chg_o
);

    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          out_q, out_d;
    logic          chg_q, chg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Two-flop synchronizer: raw pin is asynchronous to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Stability counter: any agreement with the debounced level drops the
    // accumulated count; the count never wraps, it commits at TERM.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        chg_d = 1'b0;
        if (sync2_q == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            cnt_d = '0;
            out_d = sync2_q;
            chg_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounced state; the change pulse is registered with the level so it
    // is high for exactly the cycle following the update edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            out_q <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
            chg_q <= chg_d;
        end
    end

    assign out_o = out_q;
    assign chg_o = chg_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic cap_q, cap_d;

    // Sticky rise flag; a set on the same edge as a clear takes priority so
    // an edge arriving during acknowledge is not lost.
    always_comb begin
        cap_d = (out_d & ~out_q) | (cap_q & ~clr_i);
    end

    // Edge capture register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cap_q <= 1'b0;
        else          cap_q <= cap_d;
    end

    assign cap_o = cap_q;
`endif

endmodule

// Top: WIDTH independent debouncer lanes plus optional interrupt.
module switch_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq,
`endif
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] changed
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_cfg
        $error("switch_debounce: DEBOUNCE_CYCLES out of range 2..2^20");
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .raw_i   (sw_raw[g]),
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            .clr_i   (edge_clear[g]),
            .cap_o   (edge_capture[g]),
`endif
            .out_o   (out_port[g]),
            .chg_o   (changed[g])
        );
    end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic irq_q;

    // Interrupt is the registered OR of the capture flags (one cycle behind).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= |edge_capture;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with WIDTH=10, DEBOUNCE_CYCLES=4.
// Each step drives inputs just after a rising edge, waits for the next rising
// edge and samples 1 time unit later.
module tb_switch_debounce;

    localparam int W  = 10;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] out_port, changed;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [W-1:0] edge_clear = '0;
    logic [W-1:0] edge_capture;
    logic         irq;
`endif

    int n_vec = 0;
    int n_bad = 0;

    switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw_raw       (sw_raw),
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        .edge_clear   (edge_clear),
        .edge_capture (edge_capture),
        .irq          (irq),
`endif
        .out_port     (out_port),
        .changed      (changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] out;
        logic [W-1:0] chg;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [W-1:0] raw, input logic [W-1:0] clr);
        sw_raw = raw;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        edge_clear = clr;
`else
        if (clr != '0) $display("note: edge_clear ignored in this build");
`endif
        @(posedge clk);
        #1;
    endtask

    // Hold a new raw level for DC+3 edges: old value through edge DC+1,
    // new value from edge DC+2 with a one-cycle change pulse there.
    task automatic add_hold(input logic [W-1:0] raw, input logic [W-1:0] o, input logic [W-1:0] n);
        for (int i = 0; i < DC + 3; i++)
            tbl.push_back('{raw, (i < DC + 1) ? o : n, (i == DC + 1) ? (o ^ n) : '0});
    endtask

    initial begin
        // table: single-bit rise, fall, 3-cycle glitch, all bits, mixed pattern
        tbl.push_back('{10'h000, 10'h000, 10'h000});
        add_hold(10'h001, 10'h000, 10'h001);
        add_hold(10'h000, 10'h001, 10'h000);
        for (int i = 0; i < 8; i++)
            tbl.push_back('{(i < 3) ? 10'h001 : 10'h000, 10'h000, 10'h000});
        add_hold(10'h3FF, 10'h000, 10'h3FF);
        add_hold(10'h2A5, 10'h3FF, 10'h2A5);

        // reset state, checked before any clock edge
        #3;
        chk("reset_out", 32'(out_port), 32'h0);
        chk("reset_chg", 32'(changed), 32'h0);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        chk("reset_cap", 32'(edge_capture), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;

        foreach (tbl[k]) begin
            step(tbl[k].raw, '0);
            chk($sformatf("tbl%0d_out", k), 32'(out_port), 32'(tbl[k].out));
            chk($sformatf("tbl%0d_chg", k), 32'(changed), 32'(tbl[k].chg));
        end

        // async reset with out_port nonzero clears without a clock
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(out_port), 32'h0);
        chk("async_rst_chg", 32'(changed), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // switches already high at release: out after DC+2 edges
        for (int i = 1; i <= DC + 2; i++) begin
            step(10'h2A5, '0);
            chk($sformatf("rel_e%0d_out", i), 32'(out_port), (i < DC + 2) ? 32'h0 : 32'h2A5);
        end
        chk("rel_chg", 32'(changed), 32'h2A5);

        // bit 0 falling, count at 2 after 4 edges, then reset mid-count
        for (int i = 0; i < 4; i++) step(10'h2A4, '0);
        chk("midcnt_out", 32'(out_port), 32'h2A5);
        #2 reset_n = 1'b0;
        #1;
        chk("midcnt_rst_out", 32'(out_port), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 1; i <= DC + 2; i++) begin
            step(10'h2A4, '0);
            chk($sformatf("restart_e%0d_out", i), 32'(out_port), (i < DC + 2) ? 32'h0 : 32'h2A4);
        end
        chk("restart_chg", 32'(changed), 32'h2A4);

`ifdef SWITCH_DEBOUNCE_EDGE_EN
        chk("cap_after_restart", 32'(edge_capture), 32'h2A4);
        step(10'h2A4, 10'h3FF);
        chk("clear_all_cap", 32'(edge_capture), 32'h0);
        step(10'h2A4, '0);
        chk("clear_all_irq", 32'(irq), 32'h0);
        // bit 3 rises
        for (int i = 0; i < DC + 2; i++) step(10'h2AC, '0);
        chk("b3_rise_cap", 32'(edge_capture), 32'h008);
        chk("b3_rise_irq_lag", 32'(irq), 32'h0);
        step(10'h2AC, '0);
        chk("b3_rise_irq", 32'(irq), 32'h1);
        // bit 3 falls: flag stays sticky
        for (int i = 0; i < DC + 2; i++) step(10'h2A4, '0);
        chk("b3_fall_cap", 32'(edge_capture), 32'h008);
        // bit 3 rises again with clear on the same edge: set wins
        for (int i = 0; i < DC + 1; i++) step(10'h2AC, '0);
        step(10'h2AC, 10'h008);
        chk("set_wins_out", 32'(out_port), 32'h2AC);
        chk("set_wins_cap", 32'(edge_capture), 32'h008);
        // clear alone
        step(10'h2AC, 10'h008);
        chk("clear_cap", 32'(edge_capture), 32'h0);
        chk("clear_irq_lag", 32'(irq), 32'h1);
        step(10'h2AC, '0);
        chk("clear_irq", 32'(irq), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the number of switch bits debounced.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the required stable period in clk cycles (legal range 2..2^20).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, the reset: asynchronous assert, active-low.
REQ-005 The block SHALL have port sw_raw, input, WIDTH bits, the asynchronous raw switch pins.
REQ-006 The block SHALL have port out_port, output, WIDTH bits, the debounced switch vector that drives the PIO in_port.
REQ-007 The block SHALL have port changed, output, WIDTH bits, a one-cycle pulse per bit whose debounced value toggled.
REQ-008 With SWITCH_DEBOUNCE_EDGE_EN defined, the block SHALL have port edge_clear, input, WIDTH bits, a write-1-to-clear strobe.
REQ-009 With SWITCH_DEBOUNCE_EDGE_EN defined, the block SHALL have port edge_capture, output, WIDTH bits, the sticky rising-edge flags.
REQ-010 With SWITCH_DEBOUNCE_EDGE_EN defined, the block SHALL have port irq, output, 1 bit, the OR of edge_capture.

Function
REQ-011 Each sw_raw bit SHALL pass through a two-flop synchronizer (sync1 then sync2) before any other logic.
REQ-012 Each bit SHALL have an independent counter of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-013 When sync2 equals out_port for a bit, that bit's counter SHALL load 0.
REQ-014 When they differ and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 When they differ and the counter equals DEBOUNCE_CYCLES-1, out_port SHALL take sync2 and the counter SHALL load 0 on that edge.
REQ-016 A raw level held stable SHALL appear on out_port at rising edge DEBOUNCE_CYCLES+2, where edge 1 is the first edge sampling the new level.
REQ-017 Any return of sync2 to the out_port value before the terminal count SHALL discard the accumulated count; no partial credit is kept and the counter never wraps.
REQ-018 changed[i] SHALL be 1 for exactly the cycle following the edge on which out_port[i] updates, and 0 otherwise.
REQ-019 Bits SHALL be fully independent; simultaneous changes on several bits SHALL each follow REQ-013..REQ-018 unaffected by the others.

Reset
REQ-020 While reset_n is 0, sync1, sync2, out_port, changed, all counters, edge_capture and irq SHALL be 0 without waiting for clk.
REQ-021 Reset asserted mid-count SHALL abandon the count; after release debouncing SHALL restart from out_port = 0.
REQ-022 After reset release, a switch already high SHALL reach out_port after DEBOUNCE_CYCLES+2 edges and SHALL raise changed and, if enabled, edge_capture.

Configuration
REQ-023 Macro SWITCH_DEBOUNCE_EDGE_EN defined SHALL compile in edge_clear, edge_capture and irq.
REQ-024 With the macro defined, edge_capture[i] SHALL set on the edge on which out_port[i] goes 0 to 1.
REQ-025 With the macro defined, edge_capture[i] SHALL clear on an edge with edge_clear[i] = 1, and set SHALL win when set and clear coincide.
REQ-026 With the macro defined, irq SHALL be registered and equal to the OR of edge_capture one cycle later.
REQ-027 Macro SWITCH_DEBOUNCE_EDGE_EN undefined SHALL remove those three ports and their registers, leaving REQ-001..REQ-022 unchanged.

Verification (DEBOUNCE_CYCLES=4, WIDTH=10)
REQ-028 sw_raw 0x000 to 0x001 held -> out_port = 0x001 at edge 6 after the change, and changed = 0x001 for one cycle.
REQ-029 sw_raw[0] pulse high for 3 cycles then low -> out_port stays 0x000 and changed stays 0.
REQ-030 sw_raw 0x000 to 0x3FF held -> all bits update on the same edge, and changed = 0x3FF for one cycle.
REQ-031 reset_n pulled low with the bit-0 counter at 2 -> all outputs 0 immediately, and the bit-0 count restarts after release.
REQ-032 EDGE_EN defined, bit 3 rises -> edge_capture = 0x008 and irq = 1; edge_clear = 0x008 on the same edge as a new bit-3 rise -> edge_capture stays 0x008.
REQ-033 EDGE_EN defined, edge_clear = 0x008 alone -> edge_capture = 0x000 next edge, and irq = 0 one cycle later.
